// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment byte layout is {dp,g,f,e,d,c,b,a}; the table is active-low.
package seven_seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n is the glyph for hex digit n (index 0 is the rightmost byte).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_polarity(input logic [7:0] seg, input logic active_low);
    return active_low ? seg : ~seg;
  endfunction

endpackage

// File: rtl/seven_seg_scan_hex7_decode.sv
// Combinational hex nibble + decimal point to active-low segment byte.
module hex7_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {HEX_SEG[nibble][7] & ~dp, HEX_SEG[nibble][6:0]};

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered data.
// Optional LEADING_ZERO_BLANK_EN: suppress leading zero digits (digit 0 always shown).
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 64,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [4*DIGITS-1:0]                          value,
  input  logic [DIGITS-1:0]                            dp_mask,
  input  logic [DIGITS-1:0]                            blank_mask,
  input  logic                                         load,
  output logic [7:0]                                   segment,
  output logic [DIGITS-1:0]                            an,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic AL = (ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AL}};
  localparam logic [7:0] SEG_IDLE = seg_polarity(SEG_OFF, AL);

  logic [CNT_W-1:0]             cnt;
  logic [IDX_W-1:0]             idx;
  logic [DIGITS-1:0][3:0]       sh_val;
  logic [DIGITS-1:0]            sh_dp;
  logic [DIGITS-1:0]            sh_blank;
  logic [DIGITS-1:0]            blank_eff;
  logic                         in_guard;
  logic [3:0]                   cur_nib;
  logic                         cur_dp;
  logic [7:0]                   dec_seg;
  logic [DIGITS-1:0]            an_sel;

  // Prescaler and scan counter: idx advances only on the cnt wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(PRESCALE - 1)) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign digit_idx = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else if (load) begin
      sh_val   <= value;
      sh_dp    <= dp_mask;
      sh_blank <= blank_mask;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_next;
  logic [DIGITS-1:0] sh_lz;
  logic              lz_run;

  // Walk from the most significant digit down; stop at the first visible one.
  always_comb begin
    lz_next = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lz_run && value[4*i +: 4] == 4'h0 && !dp_mask[i]) lz_next[i] = 1'b1;
      else lz_run = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       sh_lz <= '0;
    else if (load) sh_lz <= lz_next;
  end

  assign blank_eff = sh_blank | sh_lz;
`else
  assign blank_eff = sh_blank;
`endif

  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = 32'(cnt) < GUARD;
    end
  endgenerate

  assign cur_nib = sh_val[idx];
  assign cur_dp  = sh_dp[idx];
  assign an_sel  = DIGITS'(1) << idx;

  hex7_decode u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst || in_guard || blank_eff[idx]) begin
      segment <= SEG_IDLE;
      an      <= AN_OFF;
    end else begin
      segment <= seg_polarity(dec_seg, AL);
      an      <= AL ? ~an_sel : an_sel;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized + directed bench for seven_seg_scan against a cycle-count reference model.
module tb_seven_seg_scan;

  localparam int D = 4;
  localparam int P = 4;
  localparam int G = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*D-1:0] value;
  logic [D-1:0]  dp_mask;
  logic [D-1:0]  blank_mask;
  logic          load;
  logic [7:0]    segment;
  logic [D-1:0]  an;
  logic [1:0]    digit_idx;

  seven_seg_scan #(.DIGITS(D), .PRESCALE(P), .GUARD(G), .ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .load       (load),
    .segment    (segment),
    .an         (an),
    .digit_idx  (digit_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: cycles since reset plus the displayed data set.
  int          cyc;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_blank, m_lz;
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] lz_of(input logic [15:0] v, input logic [3:0] dp);
    logic [3:0] m = 4'b0;
    for (int i = D - 1; i >= 1; i--) begin
      if (((v >> (4*i)) & 16'hF) == 16'h0 && !dp[i]) m[i] = 1'b1;
      else break;
    end
    return m;
  endfunction

  // One clock: predict pins from the pre-edge model state, then advance the model.
  task automatic tick();
    logic [7:0] es;
    logic [3:0] ea;
    int c, ix, nib;
    if (rst) begin
      es = 8'hFF; ea = 4'hF;
    end else begin
      c  = cyc % P;
      ix = (cyc / P) % D;
      if (c < G || m_blank[ix] || m_lz[ix]) begin
        es = 8'hFF; ea = 4'hF;
      end else begin
        nib = (m_val >> (4*ix)) & 16'hF;
        es  = seg_tab[nib];
        if (m_dp[ix]) es[7] = 1'b0;
        ea  = ~(4'b1 << ix);
      end
    end
    @(posedge clk); #1;
    if (rst) begin
      cyc = 0; m_val = '0; m_dp = '0; m_blank = '0; m_lz = '0;
    end else begin
      cyc++;
      if (load) begin
        m_val = value; m_dp = dp_mask; m_blank = blank_mask;
`ifdef LEADING_ZERO_BLANK_EN
        m_lz = lz_of(value, dp_mask);
`else
        m_lz = '0;
`endif
      end
    end
    chk("segment", 32'(segment), 32'(es));
    chk("an", 32'(an), 32'(ea));
    chk("digit_idx", 32'(digit_idx), 32'((cyc / P) % D));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value = v; dp_mask = dp; blank_mask = bl; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blank_mask = '0;
    cyc = 0; m_val = '0; m_dp = '0; m_blank = '0; m_lz = '0;
    run(2);
    rst = 1'b0;
    run(3);

    do_load(16'h12AF, 4'b0000, 4'b0000);
    run(2 * P * D);

    do_load(16'h0000, 4'b0100, 4'b0000);
    run(P * D + 2);

    do_load(16'h12AF, 4'b0000, 4'b1000);
    run(P * D + 2);

    // Mid-slot reload: after the guard cycle, load and expect the new glyph 2 cycles later.
    do_load(16'h1111, 4'b0000, 4'b0000);
    run(P * D);
    for (int i = 0; i < 2 * P && (cyc % P) != 1; i++) tick();
    do_load(16'h2222, 4'b0000, 4'b0000);
    chk("tear_old", 32'(segment == 8'hF9 || segment == 8'hFF), 32'd1);
    tick();
    chk("new_within_2", 32'(segment), 32'h0000_00A4);
    for (int i = 0; i < P * D; i++) begin
      tick();
      chk("no_tear", 32'(segment == 8'hA4 || segment == 8'hFF), 32'd1);
    end

    // Reset in the middle of the digit-2 slot.
    do_load(16'h4321, 4'b0000, 4'b0000);
    for (int i = 0; i < 2 * P * D && !(((cyc / P) % D) == 2 && (cyc % P) == 2); i++) tick();
    chk("reach_slot2", 32'((cyc / P) % D), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_idx", 32'(digit_idx), 32'd0);
    do_load(16'h4321, 4'b0000, 4'b0000);
    run(P * D + 1);

`ifdef LEADING_ZERO_BLANK_EN
    do_load(16'h0070, 4'b0000, 4'b0000);
    run(P * D + 1);
    do_load(16'h0000, 4'b0000, 4'b0000);
    run(P * D + 1);
`endif

    // Random traffic with occasional loads and resets.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      load       = ($urandom_range(0, 99) < 15);
      value      = 16'($urandom);
      dp_mask    = 4'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      tick();
    end
    rst = 1'b0; load = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
